// File: rtl/multdiv_pkg.sv
// Shared multdiv constants and the divider state encoding.
package multdiv_pkg;

  localparam int MD_WIDTH = 32;
  localparam int CNT_W    = 6;
  localparam logic [CNT_W-1:0] DIV_ITERS = 6'd32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } div_state_t;

endpackage

// File: rtl/multdiv_div_step.sv
// One restoring division iteration: shift in the next dividend bit, try to subtract the divisor.
module div_step
  import multdiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic [WIDTH-1:0] remainder,
  input  logic             dividend_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_remainder,
  output logic             quotient_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // Trial subtraction at WIDTH+1 bits; its MSB set means the divisor did not fit.
  always_comb begin
    shifted = {remainder, dividend_msb};
    trial   = shifted - {1'b0, divisor};
    if (trial[WIDTH]) begin
      next_remainder = shifted[WIDTH-1:0];
      quotient_bit   = 1'b0;
    end else begin
      next_remainder = trial[WIDTH-1:0];
      quotient_bit   = 1'b1;
    end
  end

endmodule

// File: rtl/multdiv_div.sv
// Sequential signed divider: restoring shift-subtract on magnitudes, one quotient bit per clock,
// sign applied to the quotient when the last bit is produced.
module multdiv_div
  import multdiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [CNT_W-1:0] LAST = DIV_ITERS - 6'd1;

  div_state_t       state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] remainder;
  logic [WIDTH-1:0] quotient;
  logic             negsign;

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH-1:0] next_rem;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] q_signed;
  logic             qbit;

  // Magnitudes are unsigned, so the most negative operand maps onto itself as 2^(WIDTH-1).
  always_comb begin
    abs_a    = data_operandA[WIDTH-1] ? (~data_operandA + ONE) : data_operandA;
    abs_b    = data_operandB[WIDTH-1] ? (~data_operandB + ONE) : data_operandB;
    q_next   = {quotient[WIDTH-2:0], qbit};
    q_signed = negsign ? (~q_next + ONE) : q_next;
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .remainder      (remainder),
    .dividend_msb   (dividend[WIDTH-1]),
    .divisor        (divisor),
    .next_remainder (next_rem),
    .quotient_bit   (qbit)
  );

  // Control FSM and datapath; a start strobe wins in every state, aborting any division in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      count          <= 6'd0;
      dividend       <= ZERO;
      divisor        <= ZERO;
      remainder      <= ZERO;
      quotient       <= ZERO;
      negsign        <= 1'b0;
      data_result    <= ZERO;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else if (ctrl_DIV) begin
      dividend  <= abs_a;
      divisor   <= abs_b;
      negsign   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      remainder <= ZERO;
      quotient  <= ZERO;
      count     <= 6'd0;
      if (data_operandB == ZERO) begin
        state          <= DONE;
        data_result    <= ZERO;
        data_exception <= 1'b1;
        data_resultRDY <= 1'b1;
      end else begin
        state          <= BUSY;
        data_exception <= 1'b0;
        data_resultRDY <= 1'b0;
      end
    end else begin
      case (state)
        BUSY: begin
          dividend  <= {dividend[WIDTH-2:0], 1'b0};
          remainder <= next_rem;
          quotient  <= q_next;
          count     <= count + 6'd1;
          // The final quotient bit is folded in directly so the result lands on the 32nd edge.
          if (count == LAST) begin
            state          <= DONE;
            data_result    <= q_signed;
            data_resultRDY <= 1'b1;
          end else begin
            state          <= BUSY;
            data_resultRDY <= 1'b0;
          end
        end
        DONE: begin
          state          <= IDLE;
          data_resultRDY <= 1'b0;
        end
        default: begin
          state          <= IDLE;
          data_resultRDY <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_div.sv
// Self-checking bench for multdiv_div: directed corner cases plus random operands
// against a signed-arithmetic reference.
module tb_multdiv_div;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int total = 0;
  int bad   = 0;

  multdiv_div dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Reference: signed division truncating toward zero, wrapped to 32 bits.
  task automatic model(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic exc);
    longint sa, sb, q;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0) begin
      res = 32'd0;
      exc = 1'b1;
    end else begin
      q   = sa / sb;
      res = q[31:0];
      exc = 1'b0;
    end
  endtask

  // Drive a start strobe for exactly one edge; returns 1 ns after that edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    ctrl_DIV      = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_DIV = 1'b0;
  endtask

  // Watch the cycles after a start edge (sample 0 = cycle right after it), recording pulses.
  task automatic observe(input int cycles, output int pulses, output int lat,
                         output logic [31:0] res, output logic exc);
    pulses = 0;
    lat    = -1;
    res    = 32'hx;
    exc    = 1'bx;
    for (int k = 0; k <= cycles; k++) begin
      if (k > 0) begin
        @(posedge clock);
        #1;
      end
      if (data_resultRDY === 1'b1) begin
        pulses++;
        if (lat < 0) begin
          lat = k;
          res = data_result;
          exc = data_exception;
        end
      end
    end
  endtask

  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp_res, res;
    logic        exp_exc, exc;
    int          pulses, lat;
    model(a, b, exp_res, exp_exc);
    start_op(a, b);
    observe(40, pulses, lat, res, exc);
    check({tag, ".pulses"}, pulses, 32'd1);
    check({tag, ".latency"}, lat, exp_exc ? 32'd0 : 32'd32);
    check({tag, ".result"}, res, exp_res);
    check({tag, ".exception"}, {31'd0, exc}, {31'd0, exp_exc});
    check({tag, ".hold_result"}, data_result, exp_res);
    check({tag, ".hold_exception"}, {31'd0, data_exception}, {31'd0, exp_exc});
  endtask

  initial begin
    int          pulses, lat;
    logic [31:0] res, a, b;
    logic        exc;

    reset         = 1'b1;
    ctrl_DIV      = 1'b0;
    data_operandA = 32'd0;
    data_operandB = 32'd0;
    repeat (2) @(posedge clock);
    #1;
    check("reset.result", data_result, 32'd0);
    check("reset.exception", {31'd0, data_exception}, 32'd0);
    check("reset.rdy", {31'd0, data_resultRDY}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    run_div("pos", 32'd100, 32'd7);
    run_div("neg_pos", 32'hFFFF_FF9C, 32'd7);
    run_div("neg_neg", 32'hFFFF_FF9C, 32'hFFFF_FFF9);
    run_div("div0", 32'd5, 32'd0);
    run_div("overflow", 32'h8000_0000, 32'hFFFF_FFFF);
    run_div("minint_by2", 32'h8000_0000, 32'd2);
    check("overflow_const", 32'h8000_0000, 32'h8000_0000 ^ {31'd0, data_exception});

    // Restart 10 cycles into 100/7 with 9/3: only the new operation may report.
    start_op(32'd100, 32'd7);
    observe(9, pulses, lat, res, exc);
    check("restart.early_pulses", pulses, 32'd0);
    start_op(32'd9, 32'd3);
    observe(40, pulses, lat, res, exc);
    check("restart.pulses", pulses, 32'd1);
    check("restart.latency", lat, 32'd32);
    check("restart.result", res, 32'd3);

    // Start again in the DONE cycle: old pulse still seen, new op follows 32 cycles later.
    start_op(32'd77, 32'hFFFF_FFF5);
    repeat (32) begin
      @(posedge clock);
      #1;
    end
    check("done_start.old_rdy", {31'd0, data_resultRDY}, 32'd1);
    check("done_start.old_result", data_result, 32'hFFFF_FFF9);
    start_op(32'd1000, 32'd10);
    observe(40, pulses, lat, res, exc);
    check("done_start.pulses", pulses, 32'd1);
    check("done_start.latency", lat, 32'd32);
    check("done_start.result", res, 32'd100);

    // Asynchronous reset 15 cycles into a division.
    start_op(32'd100, 32'd7);
    repeat (14) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("midreset.result", data_result, 32'd0);
    check("midreset.exception", {31'd0, data_exception}, 32'd0);
    check("midreset.rdy", {31'd0, data_resultRDY}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    observe(40, pulses, lat, res, exc);
    check("midreset.no_pulse", pulses, 32'd0);
    run_div("after_reset", 32'd50, 32'd5);

    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      case (i % 4)
        0:       b = $urandom;
        1:       b = $urandom_range(1, 255);
        2:       b = 32'd0 - $urandom_range(1, 1000);
        default: b = (i == 7) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      endcase
      run_div("random", a, b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multdiv_div.md
Name: multdiv_div

Overview:
- Sequential 32-bit signed integer divider for the multdiv unit; the inverse-direction counterpart of the multiplier path.
- Takes a one-cycle start strobe and two operands, and runs a restoring shift-subtract algorithm, one quotient bit per clock.
- Raises a one-cycle ready pulse with the quotient.
- Sits beside the multiplier inside multdiv; the shared result mux selects its output.

Parameters:
- WIDTH, 32, operand, quotient and iteration count; only 32 is verified.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- ctrl_DIV  in  1  start strobe, sampled on the rising edge.
- data_operandA  in  WIDTH  dividend, two's complement, sampled when ctrl_DIV=1.
- data_operandB  in  WIDTH  divisor, two's complement, sampled when ctrl_DIV=1.
- data_result  out  WIDTH  quotient; held stable until the next start.
- data_exception  out  1  divide-by-zero flag; valid while data_resultRDY=1 and held with the result.
- data_resultRDY  out  1  one-cycle pulse: result valid.

Behaviour:
- Reset values while reset=1, asynchronous:
  - state=IDLE, count=0, remainder=0, quotient=0.
  - data_result=0, data_exception=0, data_resultRDY=0.
- States are IDLE, BUSY and DONE.
- Start: ctrl_DIV=1 at edge N, in any state:
  - Latch |A|, |B| and the sign bits; negsign = A[31] XOR B[31].
  - Clear remainder and count, clear data_exception, enter BUSY.
- Divide by zero: B=0 at edge N:
  - Skip BUSY and enter DONE directly.
  - data_result=0, data_exception=1, data_resultRDY=1 during the cycle after edge N.
- BUSY step, one per edge:
  - Shift {remainder, dividend} left by 1.
  - trial = remainder - divisor, computed at WIDTH+1 bits.
  - If trial is non-negative: remainder=trial and the quotient LSB is 1. Otherwise remainder is unchanged and the LSB is 0.
  - count++.
- After the 32nd step, at edge N+32, enter DONE:
  - data_result = negsign ? -quotient : quotient (two's complement, truncation toward zero).
  - data_resultRDY=1 for exactly the cycle after edge N+32.
  - Total latency is 32 cycles from the start edge.
- DONE lasts one cycle, then returns to IDLE. data_resultRDY drops; data_result and data_exception hold.
- Overflow: 0x80000000 / 0xFFFFFFFF returns 0x80000000 (wraps) with data_exception=0.
- Magnitude: |0x80000000| is handled as unsigned 0x80000000; the internal magnitudes are unsigned WIDTH bits.
- Restart while BUSY: ctrl_DIV=1 aborts the current division silently, with no ready pulse for the old operation. The new operands are latched and the count restarts.
- ctrl_DIV=1 in the same cycle as DONE: the ready pulse for the finished operation is still emitted, and the new division starts.
- Reset mid-operation: the divider returns to IDLE immediately. No ready pulse is generated afterwards until a new start.
- Remainder is internal only; it is not exported.

Decomposition:
- Shared multdiv package:
  - WIDTH constant.
  - State encoding: IDLE=2'b00, BUSY=2'b01, DONE=2'b10.
  - Iteration count constant, 32; the counter is 6 bits.
- One sub-module, div_step: a combinational single restoring iteration.
  - Inputs: remainder, dividend MSB, divisor.
  - Outputs: next remainder, quotient bit.
- Two's-complement negate and absolute-value logic stays inline.

Test Plan:
- Positive operands: A=100, B=7, ctrl_DIV pulse -> data_resultRDY high exactly 32 cycles later, data_result=14, data_exception=0.
- Mixed signs: A=-100 (0xFFFFFF9C), B=7 -> data_result=0xFFFFFFF2 (-14). Also A=-100, B=-7 -> 14.
- Divide by zero: A=5, B=0 -> data_resultRDY the cycle after the start edge, data_result=0, data_exception=1. Values hold after the pulse.
- Overflow and magnitude edge cases:
  - A=0x80000000, B=0xFFFFFFFF -> data_result=0x80000000, exception=0.
  - A=0x80000000, B=2 -> 0xC0000000.
- Restart at cycle 10 of 100/7 with A=9, B=3 -> exactly one ready pulse, 32 cycles after the restart, with data_result=3.
- Reset asserted at cycle 15 of a division -> outputs go to 0 immediately with no ready pulse. A subsequent start of 50/5 -> data_result=10.
